// File: rtl/scan_demux.sv
// Serial frame capture: steps an upstream 8:1 mux through addresses 0..NBITS-1,
// waits SETTLE clocks after each address change, and assembles din LSB-first.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no frame in progress, addr held at 0, waiting for start
// S_WAIT   | settle time after an addr change, counting settle_cnt
// S_SAMPLE | din is stable for the current addr and is captured
module scan_demux #(
   parameter int NBITS  = 7,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             din,
   output logic [2:0]       addr,
   output logic             busy,
   output logic [NBITS-1:0] data,
   output logic             valid,
   output logic [7:0]       frame_cnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;

   // With no settle time the FSM goes straight from one sample to the next
   localparam logic [1:0] S_AFTER_STEP = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
   localparam logic [3:0] SETTLE_LAST  = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam logic [2:0] ADDR_LAST    = 3'(NBITS - 1);

   logic [1:0]       state;
   logic [3:0]       settle_cnt;
   logic [NBITS-2:0] shadow;

   assign busy = (state == S_WAIT) || (state == S_SAMPLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         settle_cnt <= '0;
         shadow     <= '0;
         data       <= '0;
         valid      <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               addr       <= '0;
               settle_cnt <= '0;
               if (start && !abort) begin
                  state <= S_AFTER_STEP;
               end
            end
            S_WAIT: begin
               if (abort) begin
                  state      <= S_IDLE;
                  addr       <= '0;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= S_SAMPLE;
                  end
               end
            end
            S_SAMPLE: begin
               if (abort) begin
                  state      <= S_IDLE;
                  addr       <= '0;
                  settle_cnt <= '0;
               end else if (addr == ADDR_LAST) begin
                  // Last bit bypasses the shadow and lands in data directly
                  data       <= {din, shadow};
                  valid      <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  state      <= S_IDLE;
                  addr       <= '0;
                  settle_cnt <= '0;
               end else begin
                  for (int i = 0; i < NBITS - 1; i++) begin
                     if (addr == 3'(i)) begin
                        shadow[i] <= din;
                     end
                  end
                  addr       <= addr + 3'd1;
                  settle_cnt <= '0;
                  state      <= S_AFTER_STEP;
               end
            end
            default: begin
               state      <= S_IDLE;
               addr       <= '0;
               settle_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_demux.sv
// Bench for scan_demux: one default instance (NBITS=7, SETTLE=1) and one with
// SETTLE=0, each fed by a modelled upstream mux and checked against a scoreboard.
module tb_scan_demux;

   typedef struct {
      logic [6:0] data;
      logic [7:0] cnt;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, abort_a, start_b, abort_b;
   logic [7:0] pat_a, pat_b;
   logic       din_a, din_b;
   logic [2:0] addr_a, addr_b;
   logic       busy_a, busy_b, valid_a, valid_b;
   logic [6:0] data_a, data_b;
   logic [7:0] cnt_a, cnt_b;
   logic [7:0] ecnt_a, ecnt_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   c0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign din_a = pat_a[addr_a];
   assign din_b = pat_b[addr_b];

   scan_demux u_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .din(din_a),
      .addr(addr_a), .busy(busy_a), .data(data_a), .valid(valid_a), .frame_cnt(cnt_a)
   );

   scan_demux #(.NBITS(7), .SETTLE(0)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .din(din_b),
      .addr(addr_b), .busy(busy_b), .data(data_b), .valid(valid_b), .frame_cnt(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push_a(input logic [6:0] d, input logic [7:0] c, input int cy);
      exp_t e;
      e.data = d; e.cnt = c; e.cyc = cy;
      qa.push_back(e);
   endfunction

   function automatic void push_b(input logic [6:0] d, input logic [7:0] c, input int cy);
      exp_t e;
      e.data = d; e.cnt = c; e.cyc = cy;
      qb.push_back(e);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
         step();
         n++;
      end
      check("drain_a", qa.size(), 0);
      check("drain_b", qb.size(), 0);
   endtask

   task automatic wait_addr_a(input logic [2:0] target);
      int n = 0;
      while (addr_a !== target && n < 100) begin
         step();
         n++;
      end
      check("a_reach_addr", addr_a, target);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid_a === 1'b1) begin
         check("a_valid_expected", qa.size() > 0, 1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a_data", data_a, e.data);
            check("a_frame_cnt", cnt_a, e.cnt);
            check("a_valid_cycle", cyc, e.cyc);
         end
      end
      if (valid_b === 1'b1) begin
         check("b_valid_expected", qb.size() > 0, 1);
         if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b_data", data_b, e.data);
            check("b_frame_cnt", cnt_b, e.cnt);
            check("b_valid_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      pat_a = 8'h00; pat_b = 8'h00;
      ecnt_a = 8'd0; ecnt_b = 8'd0;
      repeat (3) step();
      check("rst_addr_a", addr_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_valid_a", valid_a, 0);
      check("rst_data_a", data_a, 0);
      check("rst_cnt_a", cnt_a, 0);
      check("rst_busy_b", busy_b, 0);
      check("rst_data_b", data_b, 0);
      check("rst_cnt_b", cnt_b, 0);
      rst = 1'b0;

      // default frame: addr steps every 2 clocks, valid 14 edges after start
      pat_a = 8'b0101_0011;
      start_a = 1'b1;
      ecnt_a = ecnt_a + 8'd1;
      push_a(7'b1010011, ecnt_a, cyc + 15);
      step();
      start_a = 1'b0;
      for (int j = 0; j < 14; j++) begin
         check("a_addr_step", addr_a, j / 2);
         check("a_busy_frame", busy_a, 1);
         step();
      end
      check("a_busy_end", busy_a, 0);
      check("a_addr_end", addr_a, 0);
      check("a_valid_at_14", valid_a, 1);
      step();
      check("a_valid_one_clk", valid_a, 0);
      drain();

      // SETTLE=0: busy for 7 clocks, valid 7 edges after start
      pat_b = 8'b0011_1100;
      start_b = 1'b1;
      ecnt_b = ecnt_b + 8'd1;
      push_b(7'b0111100, ecnt_b, cyc + 8);
      step();
      start_b = 1'b0;
      for (int j = 0; j < 7; j++) begin
         check("b_busy_frame", busy_b, 1);
         check("b_addr_step", addr_b, j);
         step();
      end
      check("b_busy_end", busy_b, 0);
      check("b_valid_at_7", valid_b, 1);
      drain();

      // second start mid-frame is ignored
      pat_a = 8'h55;
      start_a = 1'b1;
      ecnt_a = ecnt_a + 8'd1;
      push_a(7'h55, ecnt_a, cyc + 15);
      step();
      start_a = 1'b0;
      repeat (4) step();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      check("a_busy_ignored_start", busy_a, 1);
      drain();
      repeat (20) step();
      check("a_cnt_after_ignored", cnt_a, ecnt_a);

      // abort at addr 3
      pat_a = 8'b0000_1111;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      wait_addr_a(3'd3);
      abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      check("abort_busy", busy_a, 0);
      check("abort_addr", addr_a, 0);
      check("abort_valid", valid_a, 0);
      check("abort_data", data_a, 7'h55);
      check("abort_cnt", cnt_a, ecnt_a);
      repeat (20) step();

      // abort on the final-sample edge wins
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      wait_addr_a(3'd6);
      step();
      check("final_busy_before", busy_a, 1);
      abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      check("final_abort_busy", busy_a, 0);
      check("final_abort_valid", valid_a, 0);
      check("final_abort_data", data_a, 7'h55);
      check("final_abort_cnt", cnt_a, ecnt_a);
      repeat (20) step();

      // start and abort together in idle: no frame
      start_a = 1'b1;
      abort_a = 1'b1;
      step();
      start_a = 1'b0;
      abort_a = 1'b0;
      check("start_abort_idle_busy", busy_a, 0);
      step();
      check("start_abort_idle_busy2", busy_a, 0);

      // SETTLE=0 back-to-back: 4 frames 8 clocks apart
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         ecnt_b = ecnt_b + 8'd1;
         push_b(7'b0111100, ecnt_b, c0 + 8 + 8 * k);
      end
      start_b = 1'b1;
      repeat (25) step();
      start_b = 1'b0;
      drain();

      // continuous start for 256 frames, 15 clocks apart, frame_cnt wraps
      pat_a = 8'b0011_0010;
      c0 = cyc;
      for (int k = 0; k < 256; k++) begin
         ecnt_a = ecnt_a + 8'd1;
         push_a(7'b0110010, ecnt_a, c0 + 15 + 15 * k);
      end
      start_a = 1'b1;
      repeat (15 * 255 + 1) step();
      start_a = 1'b0;
      drain();
      check("wrap_cnt", cnt_a, ecnt_a);

      // reset at addr 4 (with start high), then an immediate new frame
      pat_a = 8'b0110_0101;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      wait_addr_a(3'd4);
      rst = 1'b1;
      start_a = 1'b1;
      step();
      check("mid_rst_addr", addr_a, 0);
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_valid", valid_a, 0);
      check("mid_rst_data", data_a, 0);
      check("mid_rst_cnt", cnt_a, 0);
      rst = 1'b0;
      ecnt_a = 8'd1;
      ecnt_b = 8'd0;
      push_a(7'b1100101, ecnt_a, cyc + 15);
      step();
      start_a = 1'b0;
      check("post_rst_busy", busy_a, 1);
      drain();

      repeat (5) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
